// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state encoding and default widths for the pipeline controller
package cpu_pkg;
  localparam int REG_AW_DEF   = 5;
  localparam int MAX_WAIT_DEF = 16;
  localparam int CNT_W_DEF    = 32;
  localparam int WAIT_W       = 8;
  typedef enum logic [1:0] {RUN, DWAIT, HALT} state_e;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;
  // count enabled cycles, holding once every bit is set
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else if (inc_i && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard, redirect and memory-wait control for a five-stage pipeline
module pipe_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_rs1_use_i,
  input  logic              id_rs2_use_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_is_load_i,
  input  logic              ex_branch_taken_i,
  input  logic              imem_ready_i,
  input  logic              dmem_req_i,
  input  logic              dmem_ready_i,
  output logic              pc_stall_o,
  output logic              if_id_stall_o,
  output logic              if_id_flush_o,
  output logic              id_ex_flush_o,
  output logic              ex_mem_stall_o,
  output logic              timeout_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);
  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_q, timeout_d;
  logic              lu, dmem_miss, mem_hold;
  assign lu = ex_is_load_i && (ex_rd_i != '0) &&
              ((id_rs1_use_i && id_rs1_i == ex_rd_i) || (id_rs2_use_i && id_rs2_i == ex_rd_i));
  assign dmem_miss = (state_q == RUN) && dmem_req_i && !dmem_ready_i;
  // a pending data access freezes the front end and MEM; a completing wait cycle behaves as RUN
  assign mem_hold = dmem_miss || (state_q == HALT) || (state_q == DWAIT && !dmem_ready_i);
  // control outputs by priority: memory hold, redirect, load-use bubble, fetch bubble
  always_comb begin
    pc_stall_o     = 1'b0;
    if_id_stall_o  = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_stall_o = 1'b0;
    if (mem_hold) begin
      pc_stall_o     = 1'b1;
      if_id_stall_o  = 1'b1;
      ex_mem_stall_o = 1'b1;
    end else if (ex_branch_taken_i) begin
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else if (lu) begin
      pc_stall_o    = 1'b1;
      if_id_stall_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else if (!imem_ready_i) begin
      pc_stall_o    = 1'b1;
      if_id_flush_o = 1'b1;
    end
  end
  // next state: enter DWAIT on a miss, leave on ready, give up after MAX_WAIT wait cycles
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    if (dmem_miss) begin
      state_d = DWAIT;
      wait_d  = '0;
    end else if (state_q == DWAIT && dmem_ready_i) begin
      state_d = RUN;
    end else if (state_q == DWAIT && wait_q == WAIT_W'(MAX_WAIT - 1)) begin
      state_d   = HALT;
      timeout_d = 1'b1;
    end else if (state_q == DWAIT) begin
      wait_d = wait_q + 1'b1;
    end
  end
  // state, wait count and sticky timeout registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  assign timeout_o = timeout_q;
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc_i(pc_stall_o),
    .cnt_o(stall_cnt_o)
  );
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized checks of pipe_ctrl against a cycle-level reference model
module tb_pipe_ctrl;
  localparam int AW = 5;
  localparam int MW = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [AW-1:0] rs1 = '0, rs2 = '0, rd = '0;
  logic u1 = 1'b0, u2 = 1'b0, ld = 1'b0, br = 1'b0, imem = 1'b1, dreq = 1'b0, dready = 1'b0;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall, timeout;
  logic [CW-1:0] stall_cnt;
  int n_tests = 0, n_fail = 0;
  int m_mode = 0;
  int m_waited = 0;
  int m_cnt = 0;
  bit m_to = 1'b0;
  bit exp_pc = 1'b0;
  pipe_ctrl #(.REG_AW(AW), .MAX_WAIT(MW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rs1_use_i(u1), .id_rs2_use_i(u2),
    .ex_rd_i(rd), .ex_is_load_i(ld), .ex_branch_taken_i(br),
    .imem_ready_i(imem), .dmem_req_i(dreq), .dmem_ready_i(dready),
    .pc_stall_o(pc_stall), .if_id_stall_o(if_id_stall), .if_id_flush_o(if_id_flush),
    .id_ex_flush_o(id_ex_flush), .ex_mem_stall_o(ex_mem_stall),
    .timeout_o(timeout), .stall_cnt_o(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [4:0] ctl();
    return {pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall};
  endfunction
  task automatic model_reset();
    m_mode = 0;
    m_waited = 0;
    m_cnt = 0;
    m_to = 1'b0;
  endtask
  // expected controls {pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall}
  task automatic check(input string tag);
    bit hz;
    logic [4:0] e;
    hz = ld && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    if (m_mode == 2 || (m_mode == 1 && !dready) || (m_mode == 0 && dreq && !dready)) e = 5'b11001;
    else if (br) e = 5'b00110;
    else if (hz) e = 5'b11010;
    else if (!imem) e = 5'b10100;
    else e = 5'b00000;
    exp_pc = e[4];
    chk({tag, "_ctl"}, 32'(ctl()), 32'(e));
    chk({tag, "_to"}, 32'(timeout), 32'(m_to));
    chk({tag, "_cnt"}, 32'(stall_cnt), 32'(m_cnt));
    chk({tag, "_ifid_excl"}, 32'(if_id_stall & if_id_flush), 32'd0);
  endtask
  task automatic model_edge();
    if (exp_pc && m_cnt < CMAX) m_cnt++;
    if (m_mode == 0 && dreq && !dready) begin
      m_mode = 1;
      m_waited = 0;
    end else if (m_mode == 1 && dready) begin
      m_mode = 0;
    end else if (m_mode == 1) begin
      m_waited++;
      if (m_waited == MW) begin
        m_mode = 2;
        m_to = 1'b1;
      end
    end
  endtask
  task automatic cyc(input string tag);
    #1 check(tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask
  task automatic rst_pulse();
    rst = 1'b1;
    model_reset();
    #1 check("rst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic idle();
    {rs1, rs2, rd} = '0;
    {u1, u2, ld, br, dreq, dready} = '0;
    imem = 1'b1;
  endtask
  initial begin
    @(negedge clk);
    rst_pulse();
    ld = 1'b1; rd = 5'd5; rs1 = 5'd5; u1 = 1'b1;
    #1 chk("lu_ctl", 32'(ctl()), 32'b11010);
    cyc("lu");
    ld = 1'b0;
    cyc("lu_after");
    chk("lu_cnt", 32'(stall_cnt), 32'd1);
    ld = 1'b1; br = 1'b1;
    #1 chk("br_over_lu", 32'(ctl()), 32'b00110);
    cyc("br_lu");
    idle();
    rst_pulse();
    dreq = 1'b1;
    for (int i = 0; i < 4; i++) cyc("dwait");
    dready = 1'b1;
    #1 chk("dready_release", 32'(ctl()), 32'b00000);
    cyc("dready");
    idle();
    cyc("dwait_done");
    chk("dwait_cnt", 32'(stall_cnt), 32'd4);
    rst_pulse();
    imem = 1'b0;
    cyc("imem0");
    #1 chk("imem_ctl", 32'(ctl()), 32'b10100);
    cyc("imem1");
    imem = 1'b1; ld = 1'b1; rd = 5'd0; rs1 = 5'd0; u1 = 1'b1;
    #1 chk("rd0_no_lu", 32'(ctl()), 32'b00000);
    cyc("rd0");
    idle();
    rst_pulse();
    dreq = 1'b1;
    for (int i = 0; i < 5; i++) cyc("to_wait");
    chk("timeout_set", 32'(timeout), 32'd1);
    dready = 1'b1; br = 1'b1;
    for (int i = 0; i < 3; i++) cyc("halt_hold");
    chk("halt_ctl", 32'(ctl()), 32'b11001);
    idle();
    #2 rst = 1'b1;
    #1 chk("halt_async_to", 32'(timeout), 32'd0);
    chk("halt_async_ctl", 32'(ctl()), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    dreq = 1'b1;
    for (int i = 0; i < 3; i++) cyc("mid_wait");
    #2 dreq = 1'b0; rst = 1'b1;
    #1 chk("dwait_async_ctl", 32'(ctl()), 32'd0);
    chk("dwait_async_cnt", 32'(stall_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc("post_rst");
    for (int i = 0; i < 400; i++) begin
      rs1 = AW'($urandom_range(0, 3));
      rs2 = AW'($urandom_range(0, 3));
      rd = AW'($urandom_range(0, 3));
      u1 = $urandom_range(0, 1) == 1;
      u2 = $urandom_range(0, 1) == 1;
      ld = $urandom_range(0, 9) < 3;
      br = $urandom_range(0, 9) < 2;
      imem = $urandom_range(0, 9) < 8;
      dreq = $urandom_range(0, 9) < 3;
      dready = $urandom_range(0, 9) < 4;
      if (m_mode == 2 && $urandom_range(0, 5) == 0) rst_pulse();
      else cyc("rand");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have parameter REG_AW, default 5, meaning register-address width.
REQ-002 The block SHALL have parameter MAX_WAIT, default 16, meaning the maximum number of data-memory wait cycles before timeout (range 2..255).
REQ-003 The block SHALL have parameter CNT_W, default 32, meaning stall-counter width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have ports id_rs1_i and id_rs2_i, input, REG_AW bits each: source registers of the instruction in ID.
REQ-007 The block SHALL have ports id_rs1_use_i and id_rs2_use_i, input, 1 bit each: the ID instruction reads rs1 or rs2.
REQ-008 The block SHALL have ports ex_rd_i (input, REG_AW bits) and ex_is_load_i (input, 1 bit): the EX-stage destination register and a load flag.
REQ-009 The block SHALL have port ex_branch_taken_i, input, 1 bit: the EX-stage redirect.
REQ-010 The block SHALL have port imem_ready_i, input, 1 bit: the fetch data is valid this cycle.
REQ-011 The block SHALL have ports dmem_req_i and dmem_ready_i, input, 1 bit each: the MEM stage requests access, and the access completes.
REQ-012 The block SHALL have outputs pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_flush_o and ex_mem_stall_o, 1 bit each: pipeline-register controls.
REQ-013 The block SHALL have output timeout_o, 1 bit: sticky data-memory timeout.
REQ-014 The block SHALL have output stall_cnt_o, CNT_W bits: the count of cycles in which pc_stall_o was high.

Function
REQ-015 The FSM SHALL have the states RUN, DWAIT and HALT, and all control outputs SHALL be combinational from the state and inputs.
REQ-016 Load-use hazard (lu) SHALL be defined as ex_is_load_i and ex_rd_i!=0 and ((id_rs1_use_i and id_rs1_i==ex_rd_i) or (id_rs2_use_i and id_rs2_i==ex_rd_i)).
REQ-017 In RUN with dmem_req_i=1 and dmem_ready_i=0, the block SHALL assert pc_stall, if_id_stall and ex_mem_stall, deassert both flushes, and enter DWAIT at the next edge.
REQ-018 Otherwise in RUN, if ex_branch_taken_i=1, the block SHALL assert if_id_flush and id_ex_flush with no stalls, and the branch SHALL override lu and imem wait.
REQ-019 Otherwise in RUN, if lu=1, the block SHALL assert pc_stall, if_id_stall and id_ex_flush for exactly that cycle (one bubble).
REQ-020 Otherwise in RUN, if imem_ready_i=0, the block SHALL assert pc_stall and if_id_flush (bubble into ID).
REQ-021 Otherwise in RUN, all control outputs SHALL be 0.
REQ-022 In DWAIT, the block SHALL assert pc_stall, if_id_stall and ex_mem_stall every cycle, and SHALL ignore ex_branch_taken_i and lu.
REQ-023 The wait counter SHALL clear on entry to DWAIT and increment each DWAIT cycle.
REQ-024 On dmem_ready_i=1 in DWAIT, that cycle SHALL be treated as a RUN cycle with the stalls released, and the block SHALL return to RUN.
REQ-025 If the wait counter reaches MAX_WAIT-1 in DWAIT with dmem_ready_i=0, the block SHALL enter HALT and set timeout_o at the next edge.
REQ-026 In HALT, the block SHALL hold pc_stall, if_id_stall and ex_mem_stall high and both flushes low until reset, with timeout_o sticky.
REQ-027 stall_cnt_o SHALL increment on each cycle pc_stall_o=1 and saturate at all-ones.
REQ-028 A flush and a stall on the same pipeline register SHALL never be asserted together.

Reset
REQ-029 On assertion of rst, the block SHALL immediately enter RUN and clear the wait counter, stall_cnt_o and timeout_o, including when reset occurs mid-DWAIT or in HALT.
REQ-030 Control outputs during reset SHALL follow the RUN equations.

Structure
REQ-031 The state encoding and the default widths SHALL live in the shared package cpu_pkg.
REQ-032 The block SHALL be a single module, with the saturating stall counter as the optional sub-module sat_counter.

Verification
REQ-033 Directed test: ex_is_load=1, ex_rd=5, id_rs1=5, rs1_use=1 -> one cycle of pc_stall=if_id_stall=id_ex_flush=1, then all 0; stall_cnt=1.
REQ-034 Directed test: the same lu condition with ex_branch_taken=1 -> if_id_flush=id_ex_flush=1, pc_stall=0.
REQ-035 Directed test: dmem_req=1 with ready low for 3 cycles, then high -> stalls high for 3 cycles plus the first cycle, released on the ready cycle; stall_cnt=4.
REQ-036 Directed test: MAX_WAIT=4 with dmem_ready held 0 -> HALT and timeout_o=1 after 4 DWAIT cycles, held until rst.
REQ-037 Directed test: rst pulsed mid-DWAIT -> state RUN, counters 0, outputs 0 asynchronously.
REQ-038 Directed test: imem_ready=0 for 2 cycles -> pc_stall=if_id_flush=1 for both cycles; ex_rd=0 with a load -> no lu stall.
